// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int INSTR_W     = 32;
  localparam int PC_W        = 10;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory port, redirect port and decoder handshake.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int IADDR = PC_W
);

  logic             imem_req;
  logic [IADDR-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect_valid;
  logic [IADDR-1:0] redirect_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [IADDR-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_wdata,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);
  assign w_do_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to a configurable value.
module flopenr #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues 1-cycle-latency reads, buffers returns.
// Optional macro FETCH_PERF_EN adds pop and flush performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = INSTR_W,
  parameter int               IADDR    = PC_W,
  parameter int               DEPTH    = 2,
  parameter logic [IADDR-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             r_run;
  logic             r_inflight;
  logic [IADDR-1:0] r_req_pc;
  logic [IADDR-1:0] w_fetch_pc;
  logic [IADDR-1:0] w_fetch_pc_next;
  logic             w_pc_en;
  logic             w_req;
  logic             w_pop;
  logic             w_push;
  logic [CW:0]      w_credit;
  logic [CW-1:0]    w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wdata;

  assign w_pop = bus.instr_valid && bus.instr_ready;

  // Outstanding response reserves a slot, a same-cycle pop frees one.
  assign w_credit = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_req    = r_run && !bus.redirect_valid && (w_credit < (CW+1)'(DEPTH));
  assign w_push   = r_inflight && !bus.redirect_valid;

  assign w_pc_en         = w_req || bus.redirect_valid;
  assign w_fetch_pc_next = bus.redirect_valid ? {bus.redirect_pc[IADDR-1:2], 2'b00}
                                              : w_fetch_pc + IADDR'(INSTR_BYTES);

  flopenr #(
    .WIDTH     (IADDR),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_pc_en),
    .i_d     (w_fetch_pc_next),
    .o_q     (w_fetch_pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_req;
      if (w_req) r_req_pc <= w_fetch_pc;
    end
  end

  assign w_wdata = '{instr: bus.imem_rdata, pc: r_req_pc};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = w_fetch_pc;
  assign bus.instr_valid = (w_count != '0);
  assign bus.instr       = bus.instr_valid ? w_head.instr : NOP_INSTR;
  assign bus.instr_pc    = bus.instr_valid ? w_head.pc : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_pop)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected PCs, a monitor checks pops.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(32), .IADDR(10)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q [$];

  function automatic logic [31:0] tag(input logic [9:0] pc);
    return 32'hC0DE_0000 | {22'd0, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: 1-cycle read latency, junk data when no request was made.
  logic       mem_req_s;
  logic [9:0] mem_addr_s;
  always @(negedge clk) begin
    mem_req_s  <= bus.imem_req;
    mem_addr_s <= bus.imem_addr;
  end
  always @(posedge clk) begin
    if (mem_req_s) bus.imem_rdata <= tag({mem_addr_s[9:2], 2'b00});
    else           bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  // Monitor: every accepted, non-flushed head is compared against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset_n && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.instr_pc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("pop pc=%h instr=%h exp_pc=%h", bus.instr_pc, bus.instr, e);
        chk("pop_pc", 32'(bus.instr_pc), 32'(e));
        chk("pop_instr", bus.instr, tag(e));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_req"},   32'(bus.imem_req), 32'd0);
    chk({tagname, "_addr"},  32'(bus.imem_addr), 32'd0);
    chk({tagname, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tagname, "_instr"}, bus.instr, NOP_INSTR);
    chk({tagname, "_pc"},    32'(bus.instr_pc), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    @(posedge clk);
    n = 1;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;

    // Phase 1: streaming from reset
    do_reset();
    check_reset_outputs("rst1");
`ifdef FETCH_PERF_EN
    chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
    for (int i = 0; i < 6; i++) exp_q.push_back(10'(i * 4));
    release_rst();
    chk("p1_c0_req", 32'(bus.imem_req), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk("p1_req", 32'(bus.imem_req), 32'd1);
      chk("p1_addr", 32'(bus.imem_addr), 32'((k - 1) * 4));
      chk("p1_valid", 32'(bus.instr_valid), 32'(k >= 3));
    end
    wait_drain("p1_drain");

    // Phase 2: backpressure from the start
    bus.instr_ready = 1'b0;
    do_reset();
    release_rst();
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      @(negedge clk);
      chk("p2_req", 32'(bus.imem_req), 32'(k <= 2));
      if (k >= 3) begin
        chk("p2_valid", 32'(bus.instr_valid), 32'd1);
        chk("p2_head_pc", 32'(bus.instr_pc), 32'd0);
      end
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(10'(i * 4));
    next_cycle();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("p2_resume_req", 32'(bus.imem_req), 32'd1);
    chk("p2_resume_addr", 32'(bus.imem_addr), 32'd8);
    wait_drain("p2_drain");

    // Phase 3: redirect while a response is in flight
    bus.instr_ready = 1'b1;
    do_reset();
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h004);
    release_rst();
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h100;
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h104);
    exp_q.push_back(10'h108);
    @(negedge clk);
    chk("p3_redir_req", 32'(bus.imem_req), 32'd0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("p3_n1_req", 32'(bus.imem_req), 32'd1);
    chk("p3_n1_addr", 32'(bus.imem_addr), 32'h100);
    chk("p3_n1_valid", 32'(bus.instr_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("p3_n2_valid", 32'(bus.instr_valid), 32'd0);
    chk("p3_n2_addr", 32'(bus.imem_addr), 32'h104);
    next_cycle();
    @(negedge clk);
    chk("p3_n3_valid", 32'(bus.instr_valid), 32'd1);
    chk("p3_n3_pc", 32'(bus.instr_pc), 32'h100);
    wait_drain("p3_drain");

    // Phase 4: PC wrap, misaligned redirect target
    do_reset();
    release_rst();
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h3FB;
    exp_q.push_back(10'h3F8);
    exp_q.push_back(10'h3FC);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h004);
    @(negedge clk);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("p4_addr0", 32'(bus.imem_addr), 32'h3F8);
    next_cycle();
    @(negedge clk);
    chk("p4_addr1", 32'(bus.imem_addr), 32'h3FC);
    next_cycle();
    @(negedge clk);
    chk("p4_addr2", 32'(bus.imem_addr), 32'h000);
    chk("p4_req2", 32'(bus.imem_req), 32'd1);
    wait_drain("p4_drain");

    // Phase 5: reset asserted with a request in flight
    do_reset();
    release_rst();
    next_cycle();
    @(negedge clk);
    chk("p5_req_before", 32'(bus.imem_req), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("p5_midrst");
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h004);
    release_rst();
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("p5_valid", 32'(bus.instr_valid), 32'(k >= 3));
    end
    chk("p5_first_pc", 32'(bus.instr_pc), 32'h000);
    wait_drain("p5_drain");

    // Phase 6: five pops then two redirect cycles with ready low
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(10'(i * 4));
    release_rst();
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h200;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("p6_valid_after_flush", 32'(bus.instr_valid), 32'd0);
    chk("p6_addr", 32'(bus.imem_addr), 32'h200);
    chk("p6_queue", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd2);
`endif
    next_cycle();
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
